// File: rtl/pcileech_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcileech_tx_arb_pkg
//  Brief    : Shared types and widths for the 128-bit TLP transmit arbiter.
//  Revision : 1.0
// ============================================================================
package pcileech_tx_arb_pkg;

   localparam int TDATA_W = 128;
   localparam int TKEEP_W = 4;
   localparam int BEAT_W  = TDATA_W + TKEEP_W + 1;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [TDATA_W-1:0] tdata;
      logic [TKEEP_W-1:0] tkeepdw;
      logic               tlast;
   } beat_t;

   // A single source still needs a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pcileech_axis128_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pcileech_axis128_skid
//  Brief    : Two-entry registered skid buffer for 128-bit TLP beats.
//  Revision : 1.0
// ============================================================================
module pcileech_axis128_skid
   import pcileech_tx_arb_pkg::*;
(
   input  logic  clk_pcie,
   input  logic  rst_n,
   input  beat_t in_beat_i,
   input  logic  in_valid_i,
   output logic  in_ready_o,
   output beat_t out_beat_o,
   output logic  out_valid_o,
   input  logic  out_ready_i
);

   beat_t      head_q, head_d;
   beat_t      tail_q, tail_d;
   logic [1:0] cnt_q, cnt_d;
   logic       push;
   logic       pop;

   assign pop         = (cnt_q != 2'd0) && out_ready_i;
   // A push into a full buffer is fine when the head leaves on the same edge.
   assign in_ready_o  = !((cnt_q == 2'd2) && !pop);
   assign push        = in_valid_i && in_ready_o;
   assign out_valid_o = (cnt_q != 2'd0);
   assign out_beat_o  = head_q;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = in_beat_i;
            else               tail_d = in_beat_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) head_d = tail_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               head_d = in_beat_i;
            end else begin
               head_d = tail_q;
               tail_d = in_beat_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pcileech_tlps128_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pcileech_tlps128_tx_arbiter
//  Brief    : Packet-atomic round-robin merge of 128-bit TLP sources into one
//             registered AXIS stream toward the PCIe core TX.
//  Revision : 1.0
// ============================================================================
module pcileech_tlps128_tx_arbiter
   import pcileech_tx_arb_pkg::*;
#(
   parameter int NUM_SRC   = 3,
   parameter int MAX_BEATS = 64
)(
   input  logic                         clk_pcie,
   input  logic                         rst_n,
   input  logic [NUM_SRC*TDATA_W-1:0]   src_tdata,
   input  logic [NUM_SRC*TKEEP_W-1:0]   src_tkeepdw,
   input  logic [NUM_SRC-1:0]           src_tlast,
   input  logic [NUM_SRC-1:0]           src_tvalid,
   input  logic [NUM_SRC-1:0]           src_has_data,
   output logic [NUM_SRC-1:0]           src_tready,
   output logic [TDATA_W-1:0]           m_tdata,
   output logic [TKEEP_W-1:0]           m_tkeepdw,
   output logic                         m_tlast,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic                         m_has_data,
   output logic [idx_w(NUM_SRC)-1:0]    grant_idx,
   output logic                         err_overlong
);

   localparam int              GW       = idx_w(NUM_SRC);
   localparam int              CW       = $clog2(MAX_BEATS + 1);
   localparam logic [GW-1:0]   LAST_IDX = GW'(NUM_SRC - 1);
   localparam logic [CW-1:0]   BEAT_LIM = CW'(MAX_BEATS);
   localparam logic [CW-1:0]   ERR_AT   = CW'(MAX_BEATS - 1);

   arb_state_e    state_q;
   logic [GW-1:0] grant_q;
   logic [GW-1:0] rr_q;
   logic [CW-1:0] cnt_q;
   logic          err_q;

   logic [GW-1:0] pick_idx;
   logic          pick_found;
   beat_t         in_beat;
   beat_t         out_beat;
   logic          in_valid;
   logic          skid_ready;
   logic          accept;

   // First requesting source at or after the round-robin pointer, with wrap.
   always_comb begin : p_pick
      int cand;
      cand       = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         if (!pick_found && src_tvalid[GW'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = GW'(cand);
         end
      end
   end

   always_comb begin
      in_beat.tdata   = src_tdata[int'(grant_q)*TDATA_W +: TDATA_W];
      in_beat.tkeepdw = src_tkeepdw[int'(grant_q)*TKEEP_W +: TKEEP_W];
      in_beat.tlast   = src_tlast[grant_q];
   end

   assign in_valid = (state_q == ARB_BURST) && src_tvalid[grant_q];
   assign accept   = in_valid && skid_ready;

   always_comb begin
      src_tready = '0;
      if (state_q == ARB_BURST) src_tready[grant_q] = skid_ready;
   end

   // The grant is only released by an accepted tlast, never by a tvalid gap.
   always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_found) begin
                  grant_q <= pick_idx;
                  state_q <= ARB_BURST;
               end
            end
            ARB_BURST: begin
               if (accept) begin
                  if (in_beat.tlast) begin
                     rr_q    <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                     cnt_q   <= '0;
                     state_q <= ARB_IDLE;
                  end else begin
                     if (cnt_q != BEAT_LIM) cnt_q <= cnt_q + 1'b1;
                     if (cnt_q >= ERR_AT)   err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   pcileech_axis128_skid u_skid (
      .clk_pcie    (clk_pcie),
      .rst_n       (rst_n),
      .in_beat_i   (in_beat),
      .in_valid_i  (in_valid),
      .in_ready_o  (skid_ready),
      .out_beat_o  (out_beat),
      .out_valid_o (m_tvalid),
      .out_ready_i (m_tready)
   );

   assign m_tdata      = out_beat.tdata;
   assign m_tkeepdw    = out_beat.tkeepdw;
   assign m_tlast      = out_beat.tlast;
   assign m_has_data   = (|src_has_data) || m_tvalid;
   assign grant_idx    = grant_q;
   assign err_overlong = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_tlps128_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcileech_tlps128_tx_arbiter
//  Brief    : Scoreboard bench for the 128-bit TLP transmit arbiter.
//  Revision : 1.0
// ============================================================================
module tb_pcileech_tlps128_tx_arbiter;

   localparam int NS = 3;
   localparam int MB = 4;

   logic              clk_pcie = 1'b0;
   logic              rst_n;
   logic [NS*128-1:0] src_tdata;
   logic [NS*4-1:0]   src_tkeepdw;
   logic [NS-1:0]     src_tlast;
   logic [NS-1:0]     src_tvalid;
   logic [NS-1:0]     src_has_data;
   logic [NS-1:0]     src_tready;
   logic [127:0]      m_tdata;
   logic [3:0]        m_tkeepdw;
   logic              m_tlast;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_has_data;
   logic [1:0]        grant_idx;
   logic              err_overlong;

   logic [127:0] s_data  [NS];
   logic [3:0]   s_keep  [NS];
   logic         s_last  [NS];
   logic         s_valid [NS];

   assign src_tdata   = {s_data[2], s_data[1], s_data[0]};
   assign src_tkeepdw = {s_keep[2], s_keep[1], s_keep[0]};
   assign src_tlast   = {s_last[2], s_last[1], s_last[0]};
   assign src_tvalid  = {s_valid[2], s_valid[1], s_valid[0]};

   int           total;
   int           bad;
   int           cyc = 0;
   logic [132:0] exp_q[$];
   int           out_cyc_q[$];

   always #5 clk_pcie = ~clk_pcie;
   always @(posedge clk_pcie) cyc <= cyc + 1;

   pcileech_tlps128_tx_arbiter #(.NUM_SRC(NS), .MAX_BEATS(MB)) dut (
      .clk_pcie     (clk_pcie),
      .rst_n        (rst_n),
      .src_tdata    (src_tdata),
      .src_tkeepdw  (src_tkeepdw),
      .src_tlast    (src_tlast),
      .src_tvalid   (src_tvalid),
      .src_has_data (src_has_data),
      .src_tready   (src_tready),
      .m_tdata      (m_tdata),
      .m_tkeepdw    (m_tkeepdw),
      .m_tlast      (m_tlast),
      .m_tvalid     (m_tvalid),
      .m_tready     (m_tready),
      .m_has_data   (m_has_data),
      .grant_idx    (grant_idx),
      .err_overlong (err_overlong)
   );

   function automatic logic [127:0] mk(input logic [7:0] tag, input int i);
      return {tag, 24'h5A5A00, 32'hCAFE0000 | 32'(i), 24'h0, tag, 32'(i)};
   endfunction

   // Output monitor: every beat handed to the core is popped against the model.
   task automatic monitor();
      logic [132:0] got;
      logic [132:0] want;
      forever begin
         @(negedge clk_pcie);
         if (rst_n && m_tvalid && m_tready) begin
            got = {m_tdata, m_tkeepdw, m_tlast};
            out_cyc_q.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL scoreboard_extra got=%h want=none", got);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  bad++;
                  $display("FAIL scoreboard_beat got=%h want=%h", got, want);
               end
            end
         end
      end
   endtask

   task automatic send_pkt(input logic [1:0] s, input int n, input logic [7:0] tag,
                           input int base, input int last_at);
      bit acc;
      int waitc;
      for (int i = 0; i < n; i++) begin
         s_data[s]  = mk(tag, base + i);
         s_keep[s]  = 4'hF;
         s_last[s]  = (i == last_at);
         s_valid[s] = 1'b1;
         acc   = 1'b0;
         waitc = 0;
         while (!acc && waitc < 200) begin
            @(negedge clk_pcie);
            acc = src_tready[s] && rst_n;
            @(posedge clk_pcie);
            #1;
            waitc++;
         end
         if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout src=%0d beat=%0d got=no_accept want=accept", s, i);
            s_valid[s] = 1'b0;
            return;
         end
      end
      s_valid[s] = 1'b0;
      s_last[s]  = 1'b0;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NS; i++) s_valid[i] = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk_pcie);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(output bit ok);
      for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clk_pcie);
      repeat (4) @(negedge clk_pcie);
      ok = (exp_q.size() == 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      total++; if (m_tvalid !== 1'b0)     begin bad++; $display("FAIL reset_m_tvalid got=%b want=0", m_tvalid); end
      total++; if (src_tready !== 3'b000) begin bad++; $display("FAIL reset_src_tready got=%b want=000", src_tready); end
      total++; if (err_overlong !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_overlong); end
      total++; if (grant_idx !== 2'd0)    begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_idx); end
      total++; if ({m_tdata, m_tkeepdw, m_tlast} !== 133'd0) begin bad++; $display("FAIL reset_m_data got=%h want=0", m_tdata); end
      repeat (2) @(posedge clk_pcie);
      #1;
      rst_n = 1'b1;
      @(negedge clk_pcie);
      total++; if (m_has_data !== 1'b0) begin bad++; $display("FAIL has_data_idle got=%b want=0", m_has_data); end
      src_has_data = 3'b100;
      #1;
      total++; if (m_has_data !== 1'b1) begin bad++; $display("FAIL has_data_src2 got=%b want=1", m_has_data); end
      src_has_data = 3'b000;
   endtask

   task automatic test_single_cfg();
      bit ok;
      @(posedge clk_pcie);
      #1;
      exp_q.push_back({128'h4A000001, 4'b1111, 1'b1});
      s_data[0] = 128'h4A000001; s_keep[0] = 4'b1111; s_last[0] = 1'b1; s_valid[0] = 1'b1;
      @(negedge clk_pcie);
      total++; if (src_tready[0] !== 1'b0) begin bad++; $display("FAIL cfg_ready_idle got=%b want=0", src_tready[0]); end
      @(negedge clk_pcie);
      total++; if (src_tready[0] !== 1'b1) begin bad++; $display("FAIL cfg_ready_lat1 got=%b want=1", src_tready[0]); end
      total++; if (m_tvalid !== 1'b0)      begin bad++; $display("FAIL cfg_valid_early got=%b want=0", m_tvalid); end
      @(posedge clk_pcie);
      #1;
      s_valid[0] = 1'b0; s_last[0] = 1'b0;
      @(negedge clk_pcie);
      total++; if (m_tvalid !== 1'b1)  begin bad++; $display("FAIL cfg_valid_lat2 got=%b want=1", m_tvalid); end
      total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL cfg_grant got=%0d want=0", grant_idx); end
      @(negedge clk_pcie);
      total++; if (m_tvalid !== 1'b0)  begin bad++; $display("FAIL cfg_one_beat got=%b want=0", m_tvalid); end
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL cfg_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [7:0] tags [NS];
      tags[0] = 8'hA0; tags[1] = 8'hB1; tags[2] = 8'hC2;
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < NS; s++)
            exp_q.push_back({mk(tags[s], p), 4'hF, 1'b1});
      fork
         begin send_pkt(2'd0, 1, 8'hA0, 0, 0); send_pkt(2'd0, 1, 8'hA0, 1, 0); end
         begin send_pkt(2'd1, 1, 8'hB1, 0, 0); send_pkt(2'd1, 1, 8'hB1, 1, 0); end
         begin send_pkt(2'd2, 1, 8'hC2, 0, 0); send_pkt(2'd2, 1, 8'hC2, 1, 0); end
      join
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
      total++; if (grant_idx !== 2'd2) begin bad++; $display("FAIL rr_last_grant got=%0d want=2", grant_idx); end
   endtask

   task automatic test_atomicity();
      bit ok;
      @(posedge clk_pcie);
      #1;
      out_cyc_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back({mk(8'hB1, 10 + i), 4'hF, (i == 3)});
      exp_q.push_back({mk(8'hA0, 7), 4'hF, 1'b1});
      fork
         send_pkt(2'd1, 4, 8'hB1, 10, 3);
         begin repeat (2) @(posedge clk_pcie); #1; send_pkt(2'd0, 1, 8'hA0, 7, 0); end
         begin
            repeat (4) @(negedge clk_pcie);
            total++; if (src_tready[0] !== 1'b0) begin bad++; $display("FAIL atom_src0_blocked got=%b want=0", src_tready[0]); end
            total++; if (grant_idx !== 2'd1)     begin bad++; $display("FAIL atom_grant got=%0d want=1", grant_idx); end
         end
      join
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL atom_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
      total++;
      if (out_cyc_q.size() != 5) begin
         bad++; $display("FAIL atom_beat_count got=%0d want=5", out_cyc_q.size());
      end else begin
         for (int i = 1; i < 5; i++) begin
            if (out_cyc_q[i] - out_cyc_q[i-1] != ((i == 4) ? 2 : 1)) begin
               bad++;
               $display("FAIL atom_spacing beat=%0d got=%0d want=%0d", i, out_cyc_q[i] - out_cyc_q[i-1], (i == 4) ? 2 : 1);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [5:0] pat;
      int occ;
      pat = 6'b101001;
      occ = 0;
      @(posedge clk_pcie);
      #1;
      for (int i = 0; i < 8; i++) exp_q.push_back({mk(8'hC2, i), 4'hF, (i == 7)});
      fork
         send_pkt(2'd2, 8, 8'hC2, 0, 7);
         begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk_pcie); seen = m_tvalid; end
            for (int j = 0; j < 6; j++) begin @(posedge clk_pcie); #1; m_tready = pat[j]; end
            @(posedge clk_pcie);
            #1;
            m_tready = 1'b1;
         end
         begin
            for (int c = 0; c < 40; c++) begin
               @(negedge clk_pcie);
               total++;
               if (m_tvalid !== (occ != 0)) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=%b", c, m_tvalid, occ != 0); end
               if (occ == 2 && m_tready == 1'b0) begin
                  total++;
                  if (src_tready[2] !== 1'b0) begin bad++; $display("FAIL bp_full_ready cyc=%0d got=%b want=0", c, src_tready[2]); end
               end
               if (src_tvalid[2] && src_tready[2]) occ++;
               if (m_tvalid && m_tready) occ--;
            end
         end
      join
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_overlong();
      bit ok;
      int acc;
      acc = 0;
      do_reset();
      total++; if (err_overlong !== 1'b0) begin bad++; $display("FAIL ovl_clear got=%b want=0", err_overlong); end
      for (int i = 0; i < 6; i++) exp_q.push_back({mk(8'hD3, i), 4'hF, (i == 5)});
      fork
         send_pkt(2'd1, 6, 8'hD3, 0, 5);
         begin
            for (int c = 0; c < 30; c++) begin
               @(negedge clk_pcie);
               total++;
               if (err_overlong !== (acc >= MB)) begin bad++; $display("FAIL ovl_flag accepted=%0d got=%b want=%b", acc, err_overlong, acc >= MB); end
               if (src_tvalid[1] && src_tready[1]) acc++;
            end
         end
      join
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL ovl_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
      total++; if (err_overlong !== 1'b1) begin bad++; $display("FAIL ovl_sticky got=%b want=1", err_overlong); end
   endtask

   task automatic test_async_reset();
      bit ok;
      @(posedge clk_pcie);
      #1;
      exp_q.push_back({mk(8'h50, 0), 4'hF, 1'b0});
      send_pkt(2'd0, 2, 8'h50, 0, 99);
      total++; if (m_tvalid !== 1'b1)      begin bad++; $display("FAIL ar_pre_valid got=%b want=1", m_tvalid); end
      total++; if (src_tready[0] !== 1'b1) begin bad++; $display("FAIL ar_pre_ready got=%b want=1", src_tready[0]); end
      total++; if (err_overlong !== 1'b1)  begin bad++; $display("FAIL ar_pre_err got=%b want=1", err_overlong); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (m_tvalid !== 1'b0)     begin bad++; $display("FAIL ar_valid got=%b want=0", m_tvalid); end
      total++; if (src_tready !== 3'b000) begin bad++; $display("FAIL ar_ready got=%b want=000", src_tready); end
      total++; if (err_overlong !== 1'b0) begin bad++; $display("FAIL ar_err got=%b want=0", err_overlong); end
      repeat (2) @(posedge clk_pcie);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) exp_q.push_back({mk(8'h51, i), 4'hF, (i == 4)});
      send_pkt(2'd0, 5, 8'h51, 0, 4);
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL ar_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
      total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL ar_grant got=%0d want=0", grant_idx); end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      m_tready     = 1'b1;
      src_has_data = '0;
      for (int i = 0; i < NS; i++) begin
         s_data[i] = '0; s_keep[i] = '0; s_last[i] = 1'b0; s_valid[i] = 1'b0;
      end
      fork
         monitor();
      join_none
      test_reset();
      test_single_cfg();
      test_round_robin();
      test_atomicity();
      test_backpressure();
      test_overlong();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
